// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory arbiter: state encoding and a constant log2 helper.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      r = ((32'sd1 <<< i) < v) ? (i + 1) : r;
    end
    return r;
  endfunction

endpackage

// File: rtl/mem_arb_dff.sv
// Generic register cell with synchronous active-high reset and write enable.
module mem_arb_dff #(
  parameter int           W       = 1,
  parameter logic [W-1:0] RST_VAL = {W{1'b0}}
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_wen,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  // Storage with reset priority over the write enable
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_q <= RST_VAL;
    end else if (i_wen) begin
      o_q <= i_d;
    end
  end

endmodule

// File: rtl/mem_arb_picker.sv
// Read-channel picker: one-hot grant plus binary index. With ARB_ROUND_ROBIN_EN the search
// starts at i_ptr and wraps; otherwise the lowest requesting index wins.
module mem_arb_picker
  import mem_arb_pkg::*;
#(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  i_req,
`ifdef ARB_ROUND_ROBIN_EN
  input  logic [IW-1:0] i_ptr,
`endif
  output logic [N-1:0]  o_gnt,
  output logic [IW-1:0] o_idx,
  output logic          o_any
);

  // Lowest requester overall, and (round-robin only) lowest requester at or above the pointer
  always_comb begin
    logic          w_lo_found;
    logic [IW-1:0] w_lo_idx;
    logic          w_hi_found;
    logic [IW-1:0] w_hi_idx;
    w_lo_found = 1'b0;
    w_lo_idx   = {IW{1'b0}};
    w_hi_found = 1'b0;
    w_hi_idx   = {IW{1'b0}};
    for (int i = 0; i < N; i++) begin
      w_lo_idx   = (i_req[i] && !w_lo_found) ? IW'(i) : w_lo_idx;
      w_lo_found = w_lo_found | i_req[i];
`ifdef ARB_ROUND_ROBIN_EN
      w_hi_idx   = (i_req[i] && !w_hi_found && (IW'(i) >= i_ptr)) ? IW'(i) : w_hi_idx;
      w_hi_found = w_hi_found | (i_req[i] && (IW'(i) >= i_ptr));
`endif
    end
    o_any = w_lo_found;
    o_idx = w_hi_found ? w_hi_idx : w_lo_idx;
    o_gnt = w_lo_found ? (N'(1) << o_idx) : {N{1'b0}};
  end

endmodule

// File: rtl/mem_arbiter.sv
// One write port and NUM_RD burst-read channels onto a single pipelined memory.
// Define ARB_ROUND_ROBIN_EN for round-robin read arbitration; default is fixed priority.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_RD    = 2,
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16,
  parameter int BURST_LEN = 4,
  parameter int MEM_LAT   = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_wr_req,
  input  logic [ADDR_W-1:0]        i_wr_addr,
  input  logic [DATA_W-1:0]        i_wr_data,
  output logic                     o_wr_ready,
  input  logic [NUM_RD-1:0]        i_rd_req,
  input  logic [NUM_RD*ADDR_W-1:0] i_rd_addr,
  output logic [NUM_RD-1:0]        o_rd_grant,
  output logic [NUM_RD-1:0]        o_rd_valid,
  output logic                     o_rd_last,
  output logic [DATA_W-1:0]        o_rd_data,
  output logic                     o_busy,
  output logic                     o_mem_en,
  output logic                     o_mem_wr,
  output logic [ADDR_W-1:0]        o_mem_addr,
  output logic [DATA_W-1:0]        o_mem_wdata,
  input  logic [DATA_W-1:0]        i_mem_rdata,
  input  logic                     i_mem_rvalid
);

  localparam int CW = (clog2(BURST_LEN) < 1) ? 1 : clog2(BURST_LEN);
  localparam int IW = (clog2(NUM_RD) < 1) ? 1 : clog2(NUM_RD);
  localparam int TW = clog2(MEM_LAT + 3);
  localparam logic [CW-1:0]     LAST_CNT = CW'(BURST_LEN - 1);
  localparam logic [TW-1:0]     TMO_CNT  = TW'(MEM_LAT + 1);
  localparam logic [ADDR_W-1:0] OFS_MASK = ADDR_W'(BURST_LEN - 1);

  logic [1:0]        r_state, w_state_nxt;
  logic [CW-1:0]     r_icnt, w_icnt_nxt;
  logic [CW-1:0]     r_rcnt, w_rcnt_nxt;
  logic [TW-1:0]     r_tcnt, w_tcnt_nxt;
  logic [ADDR_W-1:0] r_base, w_sel_addr;
  logic [IW-1:0]     r_win;
  logic              w_fire;
  logic [NUM_RD-1:0] w_pick_gnt;
  logic [IW-1:0]     w_pick_idx;
  logic              w_pick_any;

`ifdef ARB_ROUND_ROBIN_EN
  logic [IW-1:0] r_rr_ptr, w_rr_nxt;
  assign w_rr_nxt = (w_pick_idx == IW'(NUM_RD - 1)) ? {IW{1'b0}} : (w_pick_idx + IW'(1));
  mem_arb_dff #(.W(IW)) u_rr_ptr (.i_clk(i_clk), .i_rst(i_rst), .i_wen(w_fire), .i_d(w_rr_nxt), .o_q(r_rr_ptr));
`endif

  mem_arb_picker #(.N(NUM_RD), .IW(IW)) u_picker (
    .i_req (i_rd_req),
`ifdef ARB_ROUND_ROBIN_EN
    .i_ptr (r_rr_ptr),
`endif
    .o_gnt (w_pick_gnt),
    .o_idx (w_pick_idx),
    .o_any (w_pick_any)
  );

  // Address of the winning channel, later aligned to the burst boundary
  always_comb begin
    w_sel_addr = {ADDR_W{1'b0}};
    for (int i = 0; i < NUM_RD; i++) begin
      w_sel_addr = (w_pick_idx == IW'(i)) ? i_rd_addr[i*ADDR_W +: ADDR_W] : w_sel_addr;
    end
  end

  mem_arb_dff #(.W(2), .RST_VAL(ST_IDLE)) u_state (.i_clk(i_clk), .i_rst(i_rst), .i_wen(1'b1), .i_d(w_state_nxt), .o_q(r_state));
  mem_arb_dff #(.W(CW)) u_icnt (.i_clk(i_clk), .i_rst(i_rst), .i_wen(1'b1), .i_d(w_icnt_nxt), .o_q(r_icnt));
  mem_arb_dff #(.W(CW)) u_rcnt (.i_clk(i_clk), .i_rst(i_rst), .i_wen(1'b1), .i_d(w_rcnt_nxt), .o_q(r_rcnt));
  mem_arb_dff #(.W(TW)) u_tcnt (.i_clk(i_clk), .i_rst(i_rst), .i_wen(1'b1), .i_d(w_tcnt_nxt), .o_q(r_tcnt));
  mem_arb_dff #(.W(ADDR_W)) u_base (.i_clk(i_clk), .i_rst(i_rst), .i_wen(w_fire), .i_d(w_sel_addr & ~OFS_MASK), .o_q(r_base));
  mem_arb_dff #(.W(IW)) u_win (.i_clk(i_clk), .i_rst(i_rst), .i_wen(w_fire), .i_d(w_pick_idx), .o_q(r_win));

  // Next-state, counters and all outputs; everything is held at zero while rst is high
  always_comb begin
    w_state_nxt = r_state;
    w_icnt_nxt  = r_icnt;
    w_rcnt_nxt  = r_rcnt;
    w_tcnt_nxt  = r_tcnt;
    w_fire      = 1'b0;
    o_wr_ready  = 1'b0;
    o_rd_grant  = {NUM_RD{1'b0}};
    o_rd_valid  = {NUM_RD{1'b0}};
    o_rd_last   = 1'b0;
    o_rd_data   = {DATA_W{1'b0}};
    o_busy      = 1'b0;
    o_mem_en    = 1'b0;
    o_mem_wr    = 1'b0;
    o_mem_addr  = {ADDR_W{1'b0}};
    o_mem_wdata = {DATA_W{1'b0}};
    if (i_rst) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_ISSUE: begin
          o_busy     = 1'b1;
          o_mem_en   = 1'b1;
          o_mem_addr = r_base | ADDR_W'(r_icnt);
          if (r_icnt == LAST_CNT) begin
            w_icnt_nxt  = {CW{1'b0}};
            w_state_nxt = ST_DRAIN;
          end else begin
            w_icnt_nxt = r_icnt + CW'(1);
          end
        end
        ST_DRAIN: begin
          o_busy = 1'b1;
          if (i_mem_rvalid) begin
            w_tcnt_nxt = {TW{1'b0}};
          end else if (r_tcnt == TMO_CNT) begin
            w_tcnt_nxt  = {TW{1'b0}};
            w_rcnt_nxt  = {CW{1'b0}};
            w_state_nxt = ST_IDLE;
          end else begin
            w_tcnt_nxt = r_tcnt + TW'(1);
          end
        end
        default: begin
          // Encoding 3 falls here and recovers as IDLE
          w_state_nxt = ST_IDLE;
          w_icnt_nxt  = {CW{1'b0}};
          w_rcnt_nxt  = {CW{1'b0}};
          w_tcnt_nxt  = {TW{1'b0}};
          if (i_wr_req) begin
            o_wr_ready  = 1'b1;
            o_mem_en    = 1'b1;
            o_mem_wr    = 1'b1;
            o_mem_addr  = i_wr_addr;
            o_mem_wdata = i_wr_data;
          end else if (w_pick_any) begin
            o_rd_grant  = w_pick_gnt;
            w_fire      = 1'b1;
            w_state_nxt = ST_ISSUE;
          end else begin
            w_fire = 1'b0;
          end
        end
      endcase
      if (i_mem_rvalid && ((r_state == ST_ISSUE) || (r_state == ST_DRAIN))) begin
        o_rd_valid = NUM_RD'(1) << r_win;
        o_rd_data  = i_mem_rdata;
        if (r_rcnt == LAST_CNT) begin
          o_rd_last   = 1'b1;
          w_rcnt_nxt  = {CW{1'b0}};
          w_state_nxt = (r_state == ST_DRAIN) ? ST_IDLE : w_state_nxt;
        end else begin
          w_rcnt_nxt = r_rcnt + CW'(1);
        end
      end else begin
        o_rd_valid = {NUM_RD{1'b0}};
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a fixed-latency memory stub; honours ARB_ROUND_ROBIN_EN.
module tb_mem_arbiter;

  localparam int MEM_LAT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_req;
  logic [15:0] wr_addr, wr_data;
  logic        wr_ready;
  logic [1:0]  rd_req;
  logic [31:0] rd_addr;
  logic [1:0]  rd_grant, rd_valid;
  logic        rd_last, busy, mem_en, mem_wr, mem_rvalid;
  logic [15:0] rd_data, mem_addr, mem_wdata, mem_rdata;

  logic [MEM_LAT-1:0] pv = '0;
  logic [15:0]        pa [MEM_LAT];
  logic               drop3 = 1'b0;

  int checks = 0;
  int errors = 0;

`ifdef ARB_ROUND_ROBIN_EN
  localparam logic [1:0] G2 = 2'b10;
  localparam int EXP_V0B = 0;
  localparam int EXP_V1B = 4;
`else
  localparam logic [1:0] G2 = 2'b01;
  localparam int EXP_V0B = 4;
  localparam int EXP_V1B = 0;
`endif

  mem_arbiter #(.NUM_RD(2), .ADDR_W(16), .DATA_W(16), .BURST_LEN(4), .MEM_LAT(MEM_LAT)) dut (
    .i_clk(clk), .i_rst(rst), .i_wr_req(wr_req), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
    .o_wr_ready(wr_ready), .i_rd_req(rd_req), .i_rd_addr(rd_addr), .o_rd_grant(rd_grant),
    .o_rd_valid(rd_valid), .o_rd_last(rd_last), .o_rd_data(rd_data), .o_busy(busy),
    .o_mem_en(mem_en), .o_mem_wr(mem_wr), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
    .i_mem_rdata(mem_rdata), .i_mem_rvalid(mem_rvalid)
  );

  always #5 clk = ~clk;

  // Memory stub: read data = addr ^ A5A5, returned MEM_LAT cycles after the issue cycle
  always @(posedge clk) begin
    pv[0] <= mem_en && !mem_wr;
    pa[0] <= mem_addr;
    for (int k = 1; k < MEM_LAT; k++) begin
      pv[k] <= pv[k-1];
      pa[k] <= pa[k-1];
    end
  end
  assign mem_rvalid = pv[MEM_LAT-1] && !(drop3 && (pa[MEM_LAT-1][1:0] == 2'b11));
  assign mem_rdata  = pv[MEM_LAT-1] ? (pa[MEM_LAT-1] ^ 16'hA5A5) : 16'h0000;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs until busy drops (bounded), tallying per-channel valids and last flags
  task automatic run_burst(output int ncyc, output int v0, output int v1, output int nl);
    ncyc = 0; v0 = 0; v1 = 0; nl = 0;
    while (busy && ncyc < 60) begin
      v0 += int'(rd_valid[0]);
      v1 += int'(rd_valid[1]);
      nl += int'(rd_last);
      ncyc++;
      step();
    end
  endtask

  int n, v0, v1, nl;

  initial begin
    rst = 1'b1; wr_req = 1'b0; wr_addr = 16'h0000; wr_data = 16'h0000;
    rd_req = 2'b00; rd_addr = 32'h0000_0000;
    repeat (3) step();
    rst = 1'b0;
    #1;
    chk("reset_busy", busy, 1'b0);
    chk("reset_outs", {wr_ready, rd_grant, rd_valid, rd_last, mem_en, mem_wr}, 9'd0);
    chk("reset_addr", mem_addr, 16'h0000);

    // 1: single write
    wr_req = 1'b1; wr_addr = 16'h0010; wr_data = 16'hBEEF;
    #1;
    chk("t1_ready", wr_ready, 1'b1);
    chk("t1_mem_wr", {mem_en, mem_wr}, 2'b11);
    chk("t1_addr", mem_addr, 16'h0010);
    chk("t1_wdata", mem_wdata, 16'hBEEF);
    chk("t1_busy", busy, 1'b0);
    step();
    wr_req = 1'b0;
    #1;
    chk("t1_after", {busy, wr_ready}, 2'b00);

    // 2: burst on channel 1 from an unaligned address
    rd_req = 2'b10; rd_addr = {16'h0046, 16'h0000};
    #1;
    chk("t2_grant", rd_grant, 2'b10);
    step();
    rd_req = 2'b00;
    #1;
    chk("t2_grant_pulse", rd_grant, 2'b00);
    for (int k = 0; k < 4; k++) begin
      chk("t2_issue", {busy, mem_en, mem_wr, mem_addr}, {3'b110, 16'h0044 + 16'(k)});
      step();
    end
    for (int k = 0; k < 4; k++) begin
      chk("t2_valid", {rd_valid, rd_last}, {2'b10, (k == 3)});
      chk("t2_data", rd_data, (16'h0044 + 16'(k)) ^ 16'hA5A5);
      step();
    end
    chk("t2_idle", {busy, rd_valid}, 3'b000);

    // 3: contention across two bursts
    rd_addr = {16'h0200, 16'h0100}; rd_req = 2'b11;
    #1;
    chk("t3_grant1", rd_grant, 2'b01);
    step();
    run_burst(n, v0, v1, nl);
    chk("t3_len1", n, 8);
    chk("t3_v0a", v0, 4);
    chk("t3_last1", nl, 1);
    chk("t3_grant2", rd_grant, G2);
    step();
    rd_req = 2'b00;
    #1;
    run_burst(n, v0, v1, nl);
    chk("t3_len2", n, 8);
    chk("t3_v0b", v0, EXP_V0B);
    chk("t3_v1b", v1, EXP_V1B);

    // 4: write arriving mid-burst waits for IDLE and beats a pending read
    rd_addr = {16'h0200, 16'h0300}; rd_req = 2'b01;
    #1;
    chk("t4_grant", rd_grant, 2'b01);
    step();
    wr_req = 1'b1; wr_addr = 16'h0555; wr_data = 16'h1234;
    #1;
    n = 0;
    while (busy && n < 60) begin
      chk("t4_wr_wait", wr_ready, 1'b0);
      n++;
      step();
    end
    chk("t4_len", n, 8);
    chk("t4_wr_ok", {wr_ready, mem_en, mem_wr, rd_grant}, 5'b11100);
    chk("t4_wr_addr", mem_addr, 16'h0555);
    chk("t4_wr_data", mem_wdata, 16'h1234);
    step();
    wr_req = 1'b0;
    #1;
    chk("t4_rd_after", rd_grant, 2'b01);
    step();
    rd_req = 2'b00;
    #1;
    run_burst(n, v0, v1, nl);
    chk("t4_len2", n, 8);

    // 5: reset after the second returned word
    rd_addr = {16'h0400, 16'h0000}; rd_req = 2'b10;
    #1;
    step();
    rd_req = 2'b00;
    #1;
    repeat (5) step();
    chk("t5_rv2", rd_valid, 2'b10);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk("t5_outs", {wr_ready, rd_grant, rd_valid, rd_last, busy, mem_en, mem_wr}, 9'd0);
    chk("t5_bus", {mem_addr, rd_data}, 32'd0);
    step();
    chk("t5_late", {rd_valid, rd_last, busy}, 4'd0);

    // 6: final word suppressed, drain timeout
    drop3 = 1'b1;
    rd_addr = {16'h0000, 16'h0500}; rd_req = 2'b01;
    #1;
    chk("t6_grant", rd_grant, 2'b01);
    step();
    rd_req = 2'b00;
    #1;
    run_burst(n, v0, v1, nl);
    chk("t6_len", n, 4 + 3 + MEM_LAT + 2);
    chk("t6_valids", v0, 3);
    chk("t6_no_last", nl, 0);
    chk("t6_idle", busy, 1'b0);
    drop3 = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Parametrised successor to the single-port RAM controller. Arbitrates one write port and NUM_RD read channels (I-cache, D-cache, future prefetcher) onto one pipelined fixed-latency memory. Reads are BURST_LEN-word line fills issued back-to-back. Sits between the cache layer and the memory model, which is external to this block.

Parameters:
NUM_RD, 2, number of read channels; channel 0 has highest fixed priority.
ADDR_W, 16, address width in words.
DATA_W, 16, data word width.
BURST_LEN, 4, words per read burst; power of two, at least 1.
MEM_LAT, 4, cycles from mem_en to mem_rvalid; used only for the drain timeout.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  synchronous, active-high reset.
wr_req  in  1  write request.
wr_addr  in  ADDR_W  write address.
wr_data  in  DATA_W  write data.
wr_ready  out  1  write accepted this cycle.
rd_req  in  NUM_RD  per-channel read request, level.
rd_addr  in  NUM_RD*ADDR_W  per-channel burst address; channel i occupies bits [i*ADDR_W +: ADDR_W].
rd_grant  out  NUM_RD  one-hot pulse on the burst-start cycle.
rd_valid  out  NUM_RD  one-hot; the granted channel's word is on rd_data.
rd_last  out  1  final word of the burst.
rd_data  out  DATA_W  shared read data.
busy  out  1  state is not IDLE.
mem_en, mem_wr  out  1 each  memory enable and write strobe.
mem_addr  out  ADDR_W  memory address.
mem_wdata  out  DATA_W  memory write data.
mem_rdata  in  DATA_W  memory read data.
mem_rvalid  in  1  memory read data valid.

Behaviour:
- Reset: state IDLE, counters 0, round-robin pointer 0. All outputs 0 in the cycle after rst is sampled high.
- States: IDLE, ISSUE, DRAIN. The 2-bit encoding value 3 behaves as IDLE.
- IDLE:
  - wr_req has priority: wr_ready=1, mem_en=1, mem_wr=1, mem_addr=wr_addr, mem_wdata=wr_data. Completes in one cycle; state stays IDLE.
  - Otherwise, if any rd_req is set: pick winner w; latch w and base = rd_addr[w] with the low log2(BURST_LEN) bits zeroed; pulse rd_grant[w]; go to ISSUE.
  - wr_ready is 0 in every state other than IDLE.
- ISSUE: mem_en=1, mem_wr=0, mem_addr=base+icnt. icnt runs 0..BURST_LEN-1, one address per cycle, and never crosses the burst boundary. After the last issue, go to DRAIN.
- mem_rvalid is honoured in ISSUE and DRAIN:
  - rd_valid[w]=1 and rd_data=mem_rdata combinationally.
  - rcnt increments on each valid; rd_last=1 when rcnt==BURST_LEN-1.
- DRAIN: after the final word, go to IDLE. Next arbitration happens the following cycle.
- Drain timeout: if no mem_rvalid arrives for MEM_LAT+2 cycles in DRAIN, go to IDLE. rd_last is not asserted in this case.
- mem_rvalid received in IDLE is ignored.
- Dropping rd_req mid-burst does not abort the burst; all words are still delivered.
- A write arriving during a burst waits until IDLE. Writes may starve reads; the write source is bounded by the CPU.
- rst mid-burst: return to IDLE immediately; in-flight returns are dropped.
- ISSUE with BURST_LEN=1 lasts one cycle.

Optional Feature:
ARB_ROUND_ROBIN_EN
- Defined: read winner is the first requester at or after rr_ptr, wrapping. rr_ptr becomes w+1 (mod NUM_RD) on each grant.
- Undefined: fixed priority, lowest index wins. No pointer register exists.
- Write priority is identical in both builds.

Decomposition:
- Package mem_arb_pkg holds the state encoding localparams (ST_IDLE=0, ST_ISSUE=1, ST_DRAIN=2) and a clog2 function.
- One sub-module, mem_arb_picker: combinational request vector plus optional pointer, producing a one-hot grant and a binary index. Only the pointer register lives in mem_arbiter.
- State, counters and base use the team's dff cells with wen.

Test Plan:
1. Write only: wr_req=1, wr_addr=16'h0010, wr_data=16'hBEEF. Expect wr_ready=1, mem_wr=1, mem_addr=0010 in the same cycle; busy stays 0.
2. Read burst: rd_req[1]=1, rd_addr[1]=16'h0046, memory latency 4.
   - Expect rd_grant=2'b10 for one cycle.
   - Expect mem_addr 0044,0045,0046,0047 on consecutive cycles.
   - Expect four rd_valid[1] pulses, rd_last on the fourth, then busy=0.
3. Contention: rd_req=2'b11 held for two bursts.
   - Fixed-priority build: both grants go to channel 0.
   - ARB_ROUND_ROBIN_EN build: grants go 0 then 1.
4. Write during burst: assert wr_req in ISSUE. Expect wr_ready=0 until IDLE; the write is accepted in the first IDLE cycle, before a pending rd_req.
5. Reset mid-burst: assert rst after the second mem_rvalid. Expect IDLE and all outputs 0 next cycle; later mem_rvalid pulses produce no rd_valid.
6. Drain timeout: memory stub suppresses the last rvalid. Expect return to IDLE after MEM_LAT+2 DRAIN cycles, with rd_last never asserted.
